// File: rtl/bank_burst_ctrl.sv
// Burst sequencer driving one single-port bank memory (sync write, registered read).
// Optional word counters stat_wr_words/stat_rd_words are enabled by BANK_BURST_CTRL_STATS_EN.
module bank_burst_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048,
    parameter int LEN_W = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [WIDTH-1:0] wdata,
    output logic             rdata_valid,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_last,
    output logic             busy,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd_o_wr,
    output logic [WIDTH-1:0] mem_i_data,
`ifdef BANK_BURST_CTRL_STATS_EN
    output logic [31:0]      stat_wr_words,
    output logic [31:0]      stat_rd_words,
`endif
    input  logic [WIDTH-1:0] mem_o_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t             state, state_next;
    logic [AW-1:0]      addr, addr_next, addr_inc;
    logic [LEN_W-1:0]   count, count_next;

    // Explicit wrap keeps the address modulo DEPTH even when DEPTH is not a power of two.
    assign addr_inc = (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next  = state;
        addr_next   = addr;
        count_next  = count;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_rd_o_wr = 1'b0;
        mem_addr    = '0;
        mem_i_data  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_next  = req_addr;
                    count_next = req_len;
                    state_next = req_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                mem_rd_o_wr = wdata_valid;
                mem_addr    = addr;
                mem_i_data  = wdata;
                if (wdata_valid) begin
                    addr_next  = addr_inc;
                    count_next = count - 1'b1;
                    if (count == '0) state_next = IDLE;
                end
            end
            READ: begin
                mem_addr   = addr;
                addr_next  = addr_inc;
                count_next = count - 1'b1;
                if (count == '0) state_next = DRAIN;
            end
            DRAIN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Memory output is already registered; gating with the valid flag keeps rdata at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
        end else begin
            rdata_valid <= (state == READ);
            rdata_last  <= (state == READ) && (count == '0);
        end
    end

    assign rdata = rdata_valid ? mem_o_data : '0;

`ifdef BANK_BURST_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_words <= '0;
            stat_rd_words <= '0;
        end else begin
            if (mem_rd_o_wr) stat_wr_words <= stat_wr_words + 1'b1;
            if (rdata_valid) stat_rd_words <= stat_rd_words + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bank_burst_ctrl.sv
// Directed self-checking bench for bank_burst_ctrl with a behavioural bank memory.
module tb_bank_burst_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2048;
    localparam int LEN_W = 4;
    localparam int AW    = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready, req_wr;
    logic [AW-1:0]    req_addr;
    logic [LEN_W-1:0] req_len;
    logic             wdata_valid, wdata_ready;
    logic [WIDTH-1:0] wdata;
    logic             rdata_valid, rdata_last, busy;
    logic [WIDTH-1:0] rdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_rd_o_wr;
    logic [WIDTH-1:0] mem_i_data, mem_o_data;
`ifdef BANK_BURST_CTRL_STATS_EN
    logic [31:0]      stat_wr_words, stat_rd_words;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wa_q [$];
    logic [WIDTH-1:0] wd_q [$];

    always #5 clk = ~clk;

    bank_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
        .busy(busy), .mem_addr(mem_addr), .mem_rd_o_wr(mem_rd_o_wr),
        .mem_i_data(mem_i_data),
`ifdef BANK_BURST_CTRL_STATS_EN
        .stat_wr_words(stat_wr_words), .stat_rd_words(stat_rd_words),
`endif
        .mem_o_data(mem_o_data)
    );

    // Bank memory: synchronous write, registered read; every write is logged.
    always @(posedge clk) begin
        if (mem_rd_o_wr) begin
            mem[mem_addr] <= mem_i_data;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_i_data);
        end
        mem_o_data <= mem[mem_addr];
    end

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (mem_rd_o_wr !== 1'b0) begin n_fails++; $display("FAIL rst_mem_wr: got %b expected 0", mem_rd_o_wr); end
        n_checks++; if (rdata_valid !== 1'b0) begin n_fails++; $display("FAIL rst_rdata_valid: got %b expected 0", rdata_valid); end
        n_checks++; if (wdata_ready !== 1'b0) begin n_fails++; $display("FAIL rst_wdata_ready: got %b expected 0", wdata_ready); end
        n_checks++; if (rdata !== 8'h00) begin n_fails++; $display("FAIL rst_rdata: got %h expected 00", rdata); end
`ifdef BANK_BURST_CTRL_STATS_EN
        n_checks++; if (stat_wr_words !== 32'd0) begin n_fails++; $display("FAIL rst_stat_wr: got %0d expected 0", stat_wr_words); end
        n_checks++; if (stat_rd_words !== 32'd0) begin n_fails++; $display("FAIL rst_stat_rd: got %0d expected 0", stat_rd_words); end
`endif
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fails++; $display("FAIL post_rst_idle: got ready=%b busy=%b expected ready=1 busy=0", req_ready, busy); end
        n_checks++; if (mem_rd_o_wr !== 1'b0 || rdata_valid !== 1'b0) begin n_fails++; $display("FAIL post_rst_quiet: got wr=%b rvalid=%b expected 0 0", mem_rd_o_wr, rdata_valid); end
    endtask

    task automatic test_idle_wdata();
        @(posedge clk); #1; wdata_valid = 1'b1; wdata = 8'hFF;
        @(negedge clk);
        n_checks++; if (wdata_ready !== 1'b0) begin n_fails++; $display("FAIL idle_wdata_ready: got %b expected 0", wdata_ready); end
        n_checks++; if (mem_rd_o_wr !== 1'b0) begin n_fails++; $display("FAIL idle_mem_wr: got %b expected 0", mem_rd_o_wr); end
        n_checks++; if (mem_i_data !== 8'h00 || mem_addr !== 11'h000) begin n_fails++; $display("FAIL idle_mem_bus: got addr=%h data=%h expected 000 00", mem_addr, mem_i_data); end
        @(posedge clk); #1; wdata_valid = 1'b0; wdata = '0;
    endtask

    // Four-word write burst; stall_at >= 0 drops wdata_valid on that cycle.
    task automatic test_write(input int start, input logic [7:0] d0, input int stall_at);
        int base, cycles, k;
        logic [AW-1:0] ea;
        logic [7:0] ed;
        base = wa_q.size();
        cycles = (stall_at >= 0) ? 5 : 4;
        k = 0;
        @(posedge clk); #1; req_valid = 1'b1; req_wr = 1'b1; req_addr = AW'(start); req_len = 4'd3;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL wr_req_ready: got %b expected 1", req_ready); end
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            wdata_valid = (c != stall_at);
            wdata = 8'(d0 + k);
            @(negedge clk);
            ea = AW'((start + k) % DEPTH);
            n_checks++; if (wdata_ready !== 1'b1 || busy !== 1'b1) begin n_fails++; $display("FAIL wr_ready_busy c%0d: got wready=%b busy=%b expected 1 1", c, wdata_ready, busy); end
            if (c != stall_at) begin
                n_checks++; if (mem_rd_o_wr !== 1'b1 || mem_addr !== ea || mem_i_data !== 8'(d0 + k)) begin
                    n_fails++; $display("FAIL wr_word c%0d: got wr=%b addr=%h data=%h expected 1 %h %h", c, mem_rd_o_wr, mem_addr, mem_i_data, ea, 8'(d0 + k));
                end
                k++;
            end else begin
                n_checks++; if (mem_rd_o_wr !== 1'b0) begin n_fails++; $display("FAIL wr_stall: got wr=%b expected 0", mem_rd_o_wr); end
            end
        end
        @(posedge clk); #1; wdata_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_fails++; $display("FAIL wr_done_idle: got busy=%b ready=%b expected 0 1", busy, req_ready); end
        n_checks++; if (wa_q.size() - base !== 4) begin n_fails++; $display("FAIL wr_count: got %0d expected 4", wa_q.size() - base); end
        else begin
            for (int i = 0; i < 4; i++) begin
                ea = AW'((start + i) % DEPTH);
                ed = 8'(d0 + i);
                n_checks++; if (wa_q[base+i] !== ea || wd_q[base+i] !== ed) begin
                    n_fails++; $display("FAIL wr_log%0d: got addr=%h data=%h expected %h %h", i, wa_q[base+i], wd_q[base+i], ea, ed);
                end
            end
        end
    endtask

    // Four-word read burst: issue on cycles 1..4 after accept, data on 2..5, DRAIN on 5.
    task automatic test_read(input int start, input logic [7:0] d0);
        logic [AW-1:0] ea;
        @(posedge clk); #1; req_valid = 1'b1; req_wr = 1'b0; req_addr = AW'(start); req_len = 4'd3;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL rd_req_ready: got %b expected 1", req_ready); end
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (n == 1) req_valid = 1'b0;
            @(negedge clk);
            if (n <= 4) begin
                ea = AW'((start + n - 1) % DEPTH);
                n_checks++; if (mem_addr !== ea || mem_rd_o_wr !== 1'b0 || wdata_ready !== 1'b0) begin
                    n_fails++; $display("FAIL rd_issue%0d: got addr=%h wr=%b wready=%b expected %h 0 0", n, mem_addr, mem_rd_o_wr, wdata_ready, ea);
                end
            end
            if (n >= 2 && n <= 5) begin
                n_checks++; if (rdata_valid !== 1'b1 || rdata !== 8'(d0 + n - 2) || rdata_last !== (n == 5)) begin
                    n_fails++; $display("FAIL rd_data%0d: got v=%b d=%h last=%b expected 1 %h %b", n, rdata_valid, rdata, rdata_last, 8'(d0 + n - 2), (n == 5));
                end
            end else begin
                n_checks++; if (rdata_valid !== 1'b0 || rdata_last !== 1'b0) begin
                    n_fails++; $display("FAIL rd_novalid%0d: got v=%b last=%b expected 0 0", n, rdata_valid, rdata_last);
                end
            end
            if (n == 5) begin
                n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || mem_addr !== 11'h000) begin
                    n_fails++; $display("FAIL rd_drain: got busy=%b ready=%b addr=%h expected 1 0 000", busy, req_ready, mem_addr);
                end
            end
            if (n == 6) begin
                n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_fails++; $display("FAIL rd_idle: got busy=%b ready=%b expected 0 1", busy, req_ready); end
            end
        end
    endtask

    task automatic test_wrap();
        test_write(DEPTH - 2, 8'hC0, -1);
        test_read(DEPTH - 2, 8'hC0);
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 11'h010; req_len = 4'd3;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            if (n == 1) req_valid = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (rdata_valid !== 1'b1 || rdata !== 8'hB1) begin n_fails++; $display("FAIL mid_second_word: got v=%b d=%h expected 1 b1", rdata_valid, rdata); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (rdata_valid !== 1'b0 || rdata !== 8'h00) begin n_fails++; $display("FAIL mid_rst_rvalid: got v=%b d=%h expected 0 00", rdata_valid, rdata); end
        n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 11'h000) begin n_fails++; $display("FAIL mid_rst_idle: got busy=%b ready=%b addr=%h expected 0 1 000", busy, req_ready, mem_addr); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || rdata_valid !== 1'b0) begin
            n_fails++; $display("FAIL mid_rst_release: got ready=%b busy=%b v=%b expected 1 0 0", req_ready, busy, rdata_valid);
        end
    endtask

    initial begin
        test_reset();
        test_idle_wdata();
        test_write(16, 8'hA0, -1);
        test_read(16, 8'hA0);
        test_write(16, 8'hB0, 1);
        test_read(16, 8'hB0);
        test_wrap();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
